// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle HI/LO sequencer for the execute stage.
//
// Runs MULT/MULTU as an iterative shift-add multiply and DIV/DIVU as a
// restoring divide. It also writes HI/LO directly for MTHI/MTLO. The block
// owns the HI/LO registers and stalls MFHI/MFLO reads while an op is in flight.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_op              000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   op1, op2            rs / rt operands, sampled at the accepting edge only
//   rd_valid, rd_sel    MFHI/MFLO read (rd_sel: 0 = LO, 1 = HI)
//   rd_data             combinational HI/LO read mux
//   stall               rd_valid while busy
//   busy                high in RUN or FIX
//   done                one-cycle pulse after an accepted op completes
//   hi, lo, zeroFlag    result registers and registered {hi,lo}==0 flag
//   div0_err            (only with HILO_DIV0_TRAP_EN) divide-by-zero trap pulse
//
// Optional feature macro: HILO_DIV0_TRAP_EN. When it is defined, a divide by zero
// is trapped at accept time and HI/LO are left unchanged.
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             rd_valid,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zeroFlag
`ifdef HILO_DIV0_TRAP_EN
    ,
    output logic             div0_err
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // MUL: {upper accumulator, multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;   // negate product / quotient in FIX
    logic                 neg_rem_q, neg_rem_d;   // negate remainder in FIX
    logic                 div0_q, div0_d;         // divisor was zero: force LO to all-ones
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
`ifdef HILO_DIV0_TRAP_EN
    logic                 div0_err_q, div0_err_d;
`endif

    logic                 is_signed;
    logic [WIDTH-1:0]     abs1, abs2;
    logic                 trap_div0;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign is_signed = ~req_op[0];
    assign abs1      = (is_signed & op1[WIDTH-1]) ? -op1 : op1;
    assign abs2      = (is_signed & op2[WIDTH-1]) ? -op2 : op2;

`ifdef HILO_DIV0_TRAP_EN
    assign trap_div0 = req_op[1] & (op2 == '0);
`else
    assign trap_div0 = 1'b0;
`endif

    // Multiply step: conditional add into the upper half, then shift right with carry-in.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step. Remainder stays below the divisor, so bit WIDTH of the
    // trial difference is a reliable borrow flag.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, opa_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = div0_q ? '1
                    : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
`ifdef HILO_DIV0_TRAP_EN
        div0_err_d = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // Single-cycle ops pulse done next cycle; cleared below when entering RUN.
                    done_d = 1'b1;
                    if (!req_op[2]) begin
                        if (trap_div0) begin
`ifdef HILO_DIV0_TRAP_EN
                            div0_err_d = 1'b1;
`endif
                        end else begin
                            done_d    = 1'b0;
                            state_d   = StRun;
                            cnt_d     = '0;
                            is_div_d  = req_op[1];
                            acc_d     = {{WIDTH{1'b0}}, (req_op[1] ? abs1 : abs2)};
                            opa_d     = req_op[1] ? abs2 : abs1;
                            neg_res_d = is_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                            neg_rem_d = is_signed & op1[WIDTH-1] & req_op[1];
                            div0_d    = req_op[1] & (op2 == '0);
                        end
                    end else if (req_op[1:0] == 2'b00) begin
                        hi_d   = op1;
                        zero_d = ({op1, lo_q} == '0);
                    end else if (req_op[1:0] == 2'b01) begin
                        lo_d   = op1;
                        zero_d = ({hi_q, op1} == '0);
                    end
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                zero_d  = ({hi_d, lo_d} == '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef HILO_DIV0_TRAP_EN
            div0_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
`ifdef HILO_DIV0_TRAP_EN
            div0_err_q <= div0_err_d;
`endif
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign stall     = rd_valid & busy;
    assign rd_data   = rd_sel ? hi_q : lo_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zeroFlag  = zero_q;
`ifdef HILO_DIV0_TRAP_EN
    assign div0_err  = div0_err_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl (WIDTH = 32).
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd6;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        rd_valid = 1'b0;
    logic        rd_sel = 1'b0;
    logic [31:0] rd_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zeroFlag;
`ifdef HILO_DIV0_TRAP_EN
    logic        div0_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_zero = 1'b1;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .op1      (op1),
        .op2      (op2),
        .rd_valid (rd_valid),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .zeroFlag (zeroFlag)
`ifdef HILO_DIV0_TRAP_EN
        ,
        .div0_err (div0_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural model: new HI/LO/zero, expected latency (cycles after E0 until done)
    // and whether the divide-by-zero trap fires.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] mh, inout logic [31:0] ml, inout bit mz,
                                     output int lat, output bit d0);
        longint      sa, sb, q, r;
        logic [63:0] p;
        lat = 0;
        d0  = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                if (op == 3'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    p  = sa * sb;
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                end
                mh = p[63:32]; ml = p[31:0]; mz = (p == 64'd0); lat = 33;
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
`ifdef HILO_DIV0_TRAP_EN
                    d0 = 1'b1;
`else
                    mh = a; ml = 32'hFFFF_FFFF; mz = 1'b0; lat = 33;
`endif
                end else begin
                    if (op == 3'd2) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    ml = q[31:0]; mh = r[31:0]; mz = ({mh, ml} == 64'd0); lat = 33;
                end
            end
            3'd4: begin mh = a; mz = ({a, ml} == 64'd0); end
            3'd5: begin ml = a; mz = ({mh, a} == 64'd0); end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one request (called #1 after a rising edge) and wait for done. Returns in the
    // done cycle, #1 after its edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy, output int nrdy_low,
                         output int nstall, output bit rd_changed);
        logic [31:0] rd0;
        req_op = op; op1 = a; op2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'($urandom); op1 = $urandom; op2 = $urandom;
        rd0 = rd_data;
        lat = -1; nbusy = 0; nrdy_low = 0; nstall = 0; rd_changed = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) nbusy++;
            if (req_ready !== 1'b1) nrdy_low++;
            if (stall === 1'b1) nstall++;
            if (rd_data !== rd0) rd_changed = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_valid = 1'b1; rd_sel = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (zeroFlag !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zeroFlag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef HILO_DIV0_TRAP_EN
        checks++; if (div0_err !== 1'b0) begin errors++; $display("FAIL reset_div0_err: got %b want 0", div0_err); end
`endif
        rd_valid = 1'b0;
        m_hi = '0; m_lo = '0; m_zero = 1'b1;
    endtask

    task automatic test_mult();
        int lat, nb, nr, ns, el; bit rc, d0;
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, nb, nr, ns, rc);
        model_op(3'd0, 32'hFFFF_FFFD, 32'd5, m_hi, m_lo, m_zero, el, d0);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", nb); end
        checks++; if (nr !== 33) begin errors++; $display("FAIL mult_ready_low: got %0d want 33", nr); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
        checks++; if (zeroFlag !== 1'b0) begin errors++; $display("FAIL mult_zero: got %b want 0", zeroFlag); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mult_done_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_multu();
        int lat, nb, nr, ns, el; bit rc, d0;
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb, nr, ns, rc);
        model_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo, m_zero, el, d0);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo);
        end
        do_op(3'd0, 32'd0, 32'd2, lat, nb, nr, ns, rc);
        model_op(3'd0, 32'd0, 32'd2, m_hi, m_lo, m_zero, el, d0);
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || zeroFlag !== 1'b1) begin
            errors++; $display("FAIL mult_zero_result: got %h_%h z=%b want 0_0 z=1", hi, lo, zeroFlag);
        end
    endtask

    task automatic test_div();
        int lat, nb, nr, ns, el; bit rc, d0;
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, nb, nr, ns, rc);
        model_op(3'd2, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, m_zero, el, d0);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_signed: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        do_op(3'd3, 32'd7, 32'd2, lat, nb, nr, ns, rc);
        model_op(3'd3, 32'd7, 32'd2, m_hi, m_lo, m_zero, el, d0);
        checks++; if (lo !== 32'd3 || hi !== 32'd1) begin
            errors++; $display("FAIL divu: got hi=%h lo=%h want 1/3", hi, lo);
        end
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, nr, ns, rc);
        model_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, m_hi, m_lo, m_zero, el, d0);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h want 0/80000000", hi, lo);
        end
    endtask

    task automatic test_div0();
        int lat, nb, nr, ns, el; bit rc, d0;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        do_op(3'd3, 32'd7, 32'd0, lat, nb, nr, ns, rc);
        model_op(3'd3, 32'd7, 32'd0, m_hi, m_lo, m_zero, el, d0);
`ifdef HILO_DIV0_TRAP_EN
        checks++; if (lat !== 0) begin errors++; $display("FAIL div0_trap_latency: got %0d want 0", lat); end
        checks++; if (div0_err !== 1'b1) begin errors++; $display("FAIL div0_trap_err: got %b want 1", div0_err); end
        checks++; if (hi !== old_hi || lo !== old_lo) begin
            errors++; $display("FAIL div0_trap_unchanged: got %h_%h want %h_%h", hi, lo, old_hi, old_lo);
        end
        checks++; if (nb !== 0) begin errors++; $display("FAIL div0_trap_busy: got %0d want 0", nb); end
        @(posedge clk); #1;
        checks++; if (div0_err !== 1'b0) begin errors++; $display("FAIL div0_trap_pulse: got %b want 0", div0_err); end
`else
        checks++; if (lat !== 33) begin errors++; $display("FAIL div0_latency: got %0d want 33", lat); end
        checks++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h want 7/ffffffff (prev %h_%h)", hi, lo, old_hi, old_lo);
        end
        do_op(3'd2, 32'hFFFF_FFF9, 32'd0, lat, nb, nr, ns, rc);
        model_op(3'd2, 32'hFFFF_FFF9, 32'd0, m_hi, m_lo, m_zero, el, d0);
        checks++; if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_by_zero: got hi=%h lo=%h want fffffff9/ffffffff", hi, lo);
        end
`endif
    endtask

    task automatic test_mtlo_stall();
        int lat, nb, nr, ns, el; bit rc, d0;
        rd_valid = 1'b1; rd_sel = 1'b0;
        do_op(3'd5, 32'h0000_1234, 32'd9, lat, nb, nr, ns, rc);
        model_op(3'd5, 32'h0000_1234, 32'd9, m_hi, m_lo, m_zero, el, d0);
        checks++; if (lat !== 0 || nb !== 0) begin
            errors++; $display("FAIL mtlo_timing: got lat=%0d busy=%0d want 0/0", lat, nb);
        end
        checks++; if (lo !== 32'h1234 || rd_data !== 32'h1234 || stall !== 1'b0) begin
            errors++; $display("FAIL mtlo_read: got lo=%h rd=%h stall=%b want 1234/1234/0", lo, rd_data, stall);
        end
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL mtlo_hi_kept: got %h want %h", hi, m_hi); end
        rd_sel = 1'b1;
        do_op(3'd4, 32'h0000_ABCD, 32'd0, lat, nb, nr, ns, rc);
        model_op(3'd4, 32'h0000_ABCD, 32'd0, m_hi, m_lo, m_zero, el, d0);
        checks++; if (rd_data !== 32'hABCD || lo !== 32'h1234) begin
            errors++; $display("FAIL mthi_read: got rd=%h lo=%h want abcd/1234", rd_data, lo);
        end
        rd_sel = 1'b0;
        do_op(3'd0, 32'd3, 32'd4, lat, nb, nr, ns, rc);
        model_op(3'd0, 32'd3, 32'd4, m_hi, m_lo, m_zero, el, d0);
        checks++; if (ns !== 33) begin errors++; $display("FAIL stall_cycles: got %0d want 33", ns); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL stall_rd_old: got changed=%b want 0", rc); end
        checks++; if (stall !== 1'b0 || rd_data !== 32'd12) begin
            errors++; $display("FAIL stall_done_cycle: got stall=%b rd=%h want 0/0000000c", stall, rd_data);
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, nb, nr, ns, el; bit rc, d0;
        logic [2:0]  ops [4];
        logic [31:0] as [4];
        logic [31:0] bs [4];
        ops = '{3'd1, 3'd3, 3'd4, 3'd2};
        as  = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h8765_4321};
        bs  = '{32'h9ABC_DEF0, 32'd13, 32'd0, 32'hFFFF_FFF0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready);
            end
            do_op(ops[i], as[i], bs[i], lat, nb, nr, ns, rc);
            model_op(ops[i], as[i], bs[i], m_hi, m_lo, m_zero, el, d0);
            checks++; if (lat !== el || hi !== m_hi || lo !== m_lo || zeroFlag !== m_zero) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got lat=%0d %h_%h z=%b want lat=%0d %h_%h z=%b",
                         i, lat, hi, lo, zeroFlag, el, m_hi, m_lo, m_zero);
            end
        end
    endtask

    task automatic test_random();
        int lat, nb, nr, ns, el; bit rc, d0;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, lat, nb, nr, ns, rc);
            model_op(op, a, b, m_hi, m_lo, m_zero, el, d0);
            checks++; if (lat !== el) begin
                errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, el);
            end
            checks++; if (hi !== m_hi || lo !== m_lo) begin
                errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h",
                                   i, op, a, b, hi, lo, m_hi, m_lo);
            end
            checks++; if (zeroFlag !== m_zero) begin
                errors++; $display("FAIL rand_zero[%0d]: got %b want %b", i, zeroFlag, m_zero);
            end
`ifdef HILO_DIV0_TRAP_EN
            checks++; if (div0_err !== d0) begin
                errors++; $display("FAIL rand_div0_err[%0d]: got %b want %b", i, div0_err, d0);
            end
`endif
        end
    endtask

    task automatic test_reset_abort();
        int lat, nb, nr, ns, el, ndone; bit rc, d0;
        do_op(3'd4, 32'h5, 32'd0, lat, nb, nr, ns, rc);
        model_op(3'd4, 32'h5, 32'd0, m_hi, m_lo, m_zero, el, d0);
        req_op = 3'd0; op1 = 32'd3; op2 = 32'd4; req_valid = 1'b1;
        @(posedge clk); #1;                  // E0
        req_valid = 1'b0;
        repeat (9) @(posedge clk);           // E1..E9
        #1 reset = 1'b0;
        @(posedge clk); #1;                  // E10 with reset low
        reset = 1'b1;
        m_hi = '0; m_lo = '0; m_zero = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ctrl: got busy=%b done=%b ready=%b want 0/0/1", busy, done, req_ready);
        end
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || zeroFlag !== 1'b1) begin
            errors++; $display("FAIL abort_regs: got %h_%h z=%b want 0_0 z=1", hi, lo, zeroFlag);
        end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div0();
        test_mtlo_stall();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the execute stage's 64-bit HI/LO result path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode/execute and runs an iterative shift-add multiply or a restoring divide.
- Owns the HI/LO registers.
- Asserts a stall to the pipeline when MFHI/MFLO reads arrive while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product/remainder pair is 2*WIDTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- op1  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- op2  in  WIDTH  rt operand: multiplier or divisor
- rd_valid  in  1  MFHI/MFLO read request
- rd_sel  in  1  0 selects LO, 1 selects HI
- rd_data  out  WIDTH  combinational mux of current HI/LO per rd_sel
- stall  out  1  rd_valid & busy (combinational)
- busy  out  1  high while in RUN or FIX
- done  out  1  one-cycle pulse when HI/LO are updated by an accepted op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- zeroFlag  out  1  registered: {hi,lo}==0 after the last update

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, done=0, busy=0, zeroFlag=1; iteration counter=0. Reset in RUN/FIX aborts the op; no done pulse.
- Accept: handshake completes on a rising edge with req_valid & req_ready. Call that edge E0. Inputs are sampled only at E0.
- State IDLE:
  - MUL/DIV accepted: latch |op1| and |op2| (signed ops) or raw operands (unsigned ops). Latch the result sign flags. Clear the accumulator and go to RUN.
  - MTHI/MTLO: write hi or lo at E0, leave the other register unchanged. done=1 during the next cycle; stays in IDLE, busy never asserts.
  - Op 11x: accepted, done=1 next cycle, no register change.
- State RUN: one iteration per edge, E1..E{WIDTH}. counter increments each edge; at counter==WIDTH-1 go to FIX.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator. Then shift right by 1 with carry-in.
  - Divide: shift remainder:quotient left by 1, trial-subtract the divisor, restore on negative, set the quotient bit otherwise.
- State FIX, one cycle (edge E{WIDTH+1}):
  - Signed multiply: if the result is negative, negate the 2*WIDTH product.
  - Signed divide: negate the quotient if operand signs differ. Remainder takes the sign of the dividend; quotient truncates toward zero.
  - Writes: multiply sets hi=product[2W-1:W], lo=product[W-1:0]. Divide sets lo=quotient, hi=remainder.
  - Update zeroFlag, assert done for the following cycle, return to IDLE.
- Latency: MUL/DIV done high in the cycle after E33 (WIDTH=32). req_ready returns high in that same cycle, so back-to-back issue gives one op per 34 cycles.
- Divide by zero (macro off): runs full length. Result is hi=op1 and lo=all-ones, for both signed and unsigned.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- req_valid while busy: ignored (req_ready=0); the requester holds its inputs.
- rd_valid while busy: stall=1. rd_data still shows the old HI/LO, and the consumer must not use it until stall drops.
- rd_valid in the done cycle: stall=0, rd_data shows the new value.

Optional Feature:
- Macro: HILO_DIV0_TRAP_EN
- When defined:
  - Adds output div0_err (1 bit, reset 0).
  - DIV/DIVU with op2==0 skips RUN/FIX: hi and lo stay unchanged, and done and div0_err pulse together in the cycle after E0.
- When undefined: no div0_err port; divide-by-zero follows the full-length rule in Behaviour.

Test Plan:
- MULT op1=0xFFFFFFFD (-3), op2=5 -> done in cycle after E33, hi=0xFFFFFFFF, lo=0xFFFFFFF1, zeroFlag=0; busy high E1..E33, req_ready low throughout.
- MULTU op1=op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT op1=0, op2=2 -> hi=lo=0, zeroFlag=1.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op1=7, op2=2 -> lo=3, hi=1.
- DIVU op1=7, op2=0:
  - Macro off: hi=7, lo=0xFFFFFFFF after 34 cycles.
  - Macro on: div0_err=1 and done=1 in the cycle after E0, hi/lo unchanged.
- MTLO op1=0x1234 with rd_valid=1, rd_sel=0 the next cycle -> lo=0x1234, rd_data=0x1234, stall=0. During a following MULT, rd_valid=1 -> stall=1 until the done cycle.
- Start MULT, drive reset=0 at E10 -> busy=0, done never pulses, hi=lo=0, zeroFlag=1, req_ready=1 next cycle.
